// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: tracks fetch-time predictions in order, updates the predictor and flushes on a mispredict.
// Latency: predictor update, flush and redirect are registered one cycle after res_valid; stall_fetch is combinational from count.
// Backpressure: stall_fetch holds fetch while the queue is full. An optional statistics block is built when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve_ctrl #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int IDX_W        = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PC_en,
   input  logic             fetch_br,
   input  logic [IDX_W-1:0] fetch_index,
   input  logic             fetch_predict,
   input  logic [31:0]      fetch_target,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [31:0]      res_target,
   input  logic [31:0]      res_npc,
   output logic             br,
   output logic [IDX_W-1:0] index_update,
   output logic             br_taken,
   output logic [31:0]      br_target_I,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic             stall_fetch,
   output logic             err,
   output logic [15:0]      stat_resolved,
   output logic [15:0]      stat_mispredict
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = 3;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic             predict;
      logic [31:0]      target;
   } entry_t;

   typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_t;

   state_t          state;
   state_t          state_nxt;
   entry_t          mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [FW-1:0]   fcnt;

   entry_t          head_e;
   logic            in_run;
   logic            full;
   logic            push_req;
   logic            pop;
   logic            mispredict;
   logic            push;
   logic            overflow;
   logic            empty_res;

   assign head_e      = mem[head];
   assign in_run      = (state == ST_RUN);
   assign full        = (count == CW'(DEPTH));
   assign stall_fetch = full;
   assign flush       = (state == ST_FLUSH);
   assign push_req    = PC_en & fetch_br;

   // Resolutions are only accepted in RUN and only against a recorded prediction.
   assign pop        = in_run & res_valid & (count != '0);
   assign empty_res  = in_run & res_valid & (count == '0);
   assign mispredict = pop & ((head_e.predict != res_taken) |
                              (res_taken & head_e.predict & (head_e.target != res_target)));
   // A push on the same cycle as a mispredict is on the wrong path and is dropped.
   // A pop frees a slot, so push-with-pop is legal even when full.
   assign push       = in_run & push_req & ~mispredict & (~full | pop);
   assign overflow   = in_run & push_req & ~mispredict & full & ~pop;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next state: enter FLUSH on a mispredict, leave once the hold counter is exhausted.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (mispredict)   state_nxt = ST_FLUSH;
         ST_FLUSH: if (fcnt == '0)   state_nxt = ST_RUN;
         default:                    state_nxt = ST_RUN;
      endcase
   end

   // Flush hold counter: loaded on mispredict, counts down while flushing.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                fcnt <= '0;
      else if (mispredict)                    fcnt <= FW'(FLUSH_CYCLES - 1);
      else if (state == ST_FLUSH && fcnt != '0) fcnt <= fcnt - 1'b1;
   end

   // Queue pointers and occupancy; a mispredict discards every younger entry.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (mispredict) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful between head and tail, so no reset.
   always_ff @(posedge CLK) begin
      if (push) mem[tail] <= '{index: fetch_index, predict: fetch_predict, target: fetch_target};
   end

   // Predictor update port: one-cycle strobe per resolution, fields held afterwards.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         br           <= 1'b0;
         index_update <= '0;
         br_taken     <= 1'b0;
         br_target_I  <= '0;
      end else begin
         br <= pop;
         if (pop) begin
            index_update <= head_e.index;
            br_taken     <= res_taken;
            br_target_I  <= res_target;
         end
      end
   end

   // Redirect PC captured at the mispredict and held through FLUSH.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)             redirect_pc <= '0;
      else if (mispredict) redirect_pc <= res_taken ? res_target : res_npc;
   end

   // Sticky protocol error: overflow push or resolution with nothing outstanding.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                        err <= 1'b0;
      else if (overflow | empty_res)  err <= 1'b1;
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   // Saturating resolution and mispredict counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stat_resolved   <= '0;
         stat_mispredict <= '0;
      end else begin
         if (pop && stat_resolved != 16'hFFFF)          stat_resolved   <= stat_resolved + 1'b1;
         if (mispredict && stat_mispredict != 16'hFFFF) stat_mispredict <= stat_mispredict + 1'b1;
      end
   end
`else
   assign stat_resolved   = '0;
   assign stat_mispredict = '0;
`endif

endmodule
